mdio_master_ctrl: RTL and testbench
===================================

# mdio_master_ctrl

Parametrised MDIO management master generating IEEE 802.3 Clause 22 frames (Clause 45 optional) toward one or more external PHYs. Sits between the board-management logic and the PHY MDC/MDIO pins, accepting one command at a time over a valid/ready handshake. It returns read data MSB-first-corrected with a PHY-absent error flag, and provides a configurable MDC divider, preamble length and inter-frame gap. The MDIO pad tristate lives at the top level; this block exposes separate out/oe/in signals.

## Interface
- MDC_DIV, 20, iclk_100m cycles per MDC period; even, >= 4 (20 -> 5 MHz)
- PRE_LEN, 32, preamble bits of 1 sent before ST; 0..32 (0 = preamble suppression)
- GAP_CYC, 1, idle MDC periods (MDC high, MDIO released) after each frame; 0..15

- iclk_100m  in  1  system clock
- irst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  block idle, command accepted when valid & ready
- i_clause45  in  1  1 = Clause 45 frame (honoured only with MDIO_CLAUSE45_EN)
- i_op  in  2  C22: 01 write, 10 read; C45: 00 address, 01 write, 11 read, 10 read-increment
- i_phy_addr  in  5  PHYAD / PRTAD
- i_reg_addr  in  5  REGAD / DEVAD
- i_wdata  in  16  write data or C45 address
- o_rdata  out  16  read data, held until next read completes
- o_rdata_valid  out  1  one-cycle pulse, o_rdata updated
- o_done  out  1  one-cycle pulse, frame finished (every command)
- o_err  out  1  one-cycle pulse with o_done: illegal op or TA not driven low by PHY
- o_busy  out  1  high from accept through end of gap
- o_mdc  out  1  management clock
- o_mdio_out  out  1  MDIO drive value
- o_mdio_oe  out  1  MDIO drive enable
- i_mdio_in  in  1  MDIO pad input (synchronised internally, 2 flops)

## Operation
- States: IDLE, PRE, HDR, TA, DATA, GAP.
- IDLE: o_cmd_ready=1. On accept, latch all command fields; ready drops next cycle.
- Illegal op (C22 with op 00/11; C45 request without macro is treated as C22): no frame, o_done+o_err pulse the cycle after accept, return to IDLE, no gap.
- PRE: PRE_LEN ones driven (skipped when 0). HDR: ST (01 C22, 00 C45), OP, PHYAD, REGAD, MSB first, 14 bits.
- TA, write/address: master drives 1,0. TA, read: oe=0 both bits; bit 2 sampled, must be 0 else o_err set for this frame.
- DATA: write drives i_wdata[15] first. Read samples 16 bits into o_rdata MSB first (first sampled bit -> o_rdata[15]); data captured even on TA error (PHY absent yields 16'hFFFF).
- End of DATA: o_done (and o_rdata_valid for reads/read-increment) pulse, then GAP for GAP_CYC MDC periods, then IDLE.
- o_mdio_oe=1 only during PRE, HDR and write/address TA+DATA; o_mdio_out=1 whenever oe=0.

## Timing
- Phase counter 0..MDC_DIV-1 runs only outside IDLE. o_mdc=0 for count < MDC_DIV/2, else 1; o_mdc=1 in IDLE.
- Drive bits change on count 0 (MDC falling edge); input sampled on synchronised i_mdio_in at count MDC_DIV/2+2 (rising edge plus synchroniser delay).
- Accept at cycle T: first falling MDC edge at T+1; frame of PRE_LEN+32 bits; o_done at T+1+(PRE_LEN+32)*MDC_DIV; o_cmd_ready returns at o_done cycle + GAP_CYC*MDC_DIV + 1.
- Reset values: o_cmd_ready=1, o_mdc=1, o_mdio_oe=0, o_mdio_out=1, o_busy=0, o_rdata=0, all pulses 0.
- Reset asserted mid-frame: all outputs immediately to reset values, frame abandoned, no o_done.
- i_cmd_valid while busy: ignored, no queueing; fields may change freely.

## Configuration
- MDIO_CLAUSE45_EN defined: i_clause45=1 selects ST=00 and C45 op encoding, all four ops legal.
- Undefined: i_clause45 ignored, only C22 frames generated, C45-only op codes flagged illegal.

## Test plan
- C22 write PHY 5'h01 reg 5'h00 data 16'h1140, defaults -> 64 bits on MDIO = 32 ones, 0101_00001_00000_10_0001000101000000; o_done at T+1281.
- C22 read PHY 5'h03 reg 5'h02, PHY model returns TA 0 and 16'h0141 -> o_rdata=16'h0141, o_rdata_valid and o_done same cycle, o_err=0, oe low from TA onward.
- C22 read with no PHY (pull-up, input 1) -> o_rdata=16'hFFFF, o_err=1 with o_done.
- PRE_LEN=0, MDC_DIV=4 write -> frame 32 bits, o_done at T+129; op 2'b11 in C22 -> o_done+o_err at T+1, MDC idle-high.
- With MDIO_CLAUSE45_EN: address 16'h0001 to DEVAD 5'h01, then read -> ST=00, OP 00 then 11, read data returned.
- Assert irst_n low at bit 40 of a write -> o_mdc=1, oe=0 asynchronously, no o_done; next command completes normally.

Source files
------------

// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl: MDIO management master, Clause 22 frames (Clause 45 when MDIO_CLAUSE45_EN is defined).
// Latency: accept at T -> o_done at T+1+(PRE_LEN+32)*MDC_DIV; illegal op -> o_done/o_err at T+1.
// Backpressure: one command at a time; o_cmd_ready low from the cycle after accept until the gap ends.
//
// Ports:
//   iclk_100m, irst_n            system clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready    command handshake; i_clause45, i_op, i_phy_addr, i_reg_addr, i_wdata latched on accept
//   o_rdata, o_rdata_valid       read data (held until the next read completes) and its one-cycle strobe
//   o_done, o_err, o_busy        end-of-command pulse, error pulse (with o_done), activity flag
//   o_mdc, o_mdio_out/oe, i_mdio_in  PHY management pins; pad tristate lives above this block
//
// Build option: define MDIO_CLAUSE45_EN to honour i_clause45 (ST=00 and the four Clause 45 op codes).
module mdio_master_ctrl #(
  parameter int MDC_DIV = 20,
  parameter int PRE_LEN = 32,
  parameter int GAP_CYC = 1
) (
  input  logic        iclk_100m,
  input  logic        irst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_clause45,
  input  logic [1:0]  i_op,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  localparam int CW     = $clog2(MDC_DIV);
  localparam int HALF_I = MDC_DIV / 2;
  // Sample two cycles after the MDC rising edge to cover the input synchroniser.
  // With the smallest dividers that point would fall past the bit, so clamp it
  // to the last phase of the bit.
  localparam int SAMP_I = (HALF_I + 2 < MDC_DIV) ? HALF_I + 2 : MDC_DIV - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_I);
  localparam logic [CW-1:0] CNT_SAMP = CW'(SAMP_I);
  localparam int GW = $clog2(GAP_CYC * MDC_DIV + 1) + 1;
  // The gap state also covers the o_done cycle, hence GAP_CYC*MDC_DIV+1 cycles.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC * MDC_DIV);
  localparam logic [4:0] PRE_LAST = (PRE_LEN > 0) ? 5'(PRE_LEN - 1) : 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     bcnt_q, bcnt_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic [31:0]    tx_q, tx_d;
  logic           rd_q, rd_d;
  logic           ta_err_q, ta_err_d;
  logic [15:0]    rx_q, rx_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           rvld_q, rvld_d;
  logic [1:0]     sync_q;

  logic           c45_in;
  logic           legal_in;
  logic           rd_in;
  logic [1:0]     st_in;
  logic           bit_end;
  logic           sample;
  logic           mdio_s;

`ifdef MDIO_CLAUSE45_EN
  assign c45_in = i_clause45;
`else
  logic unused_clause45;
  assign unused_clause45 = i_clause45;
  assign c45_in          = 1'b0;
`endif

  // Clause 45 accepts every op code; read and read-increment both have op[1] set.
  assign legal_in = c45_in || (i_op == 2'b01) || (i_op == 2'b10);
  assign rd_in    = c45_in ? i_op[1] : (i_op == 2'b10);
  assign st_in    = c45_in ? 2'b00 : 2'b01;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign sample   = (cnt_q == CNT_SAMP);
  assign mdio_s   = sync_q[1];

  always_ff @(posedge iclk_100m or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      gcnt_q   <= '0;
      tx_q     <= '0;
      rd_q     <= 1'b0;
      ta_err_q <= 1'b0;
      rx_q     <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvld_q   <= 1'b0;
      sync_q   <= 2'b11;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      gcnt_q   <= gcnt_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      ta_err_q <= ta_err_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvld_q   <= rvld_d;
      sync_q   <= {sync_q[0], i_mdio_in};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    gcnt_d   = gcnt_q;
    tx_d     = tx_q;
    rd_d     = rd_q;
    ta_err_d = ta_err_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rvld_d   = 1'b0;

    // Phase counter free-runs across all bit-carrying states.
    if (state_q != S_IDLE && state_q != S_GAP) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    // Header, turnaround and data all leave through tx_q[31].
    if ((state_q == S_HDR || state_q == S_TA || state_q == S_DATA) && bit_end) begin
      tx_d = {tx_q[30:0], 1'b0};
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_cmd_valid) begin
          if (!legal_in) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d  = (PRE_LEN > 0) ? S_PRE : S_HDR;
            bcnt_d   = '0;
            rd_d     = rd_in;
            ta_err_d = 1'b0;
            // TA pattern 10 is only driven on writes; reads release the line.
            tx_d     = {st_in, i_op, i_phy_addr, i_reg_addr, 2'b10, i_wdata};
          end
        end
      end

      S_PRE: begin
        if (bit_end) begin
          if (bcnt_q == PRE_LAST) begin
            state_d = S_HDR;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end

      S_HDR: begin
        if (bit_end) begin
          if (bcnt_q == 5'd13) begin
            state_d = S_TA;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end

      S_TA: begin
        // A present PHY pulls the second turnaround bit low.
        if (rd_q && sample && bcnt_q == 5'd1) begin
          ta_err_d = mdio_s;
        end
        if (bit_end) begin
          if (bcnt_q == 5'd1) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end

      S_DATA: begin
        if (rd_q && sample) begin
          rx_d = {rx_q[14:0], mdio_s};
        end
        if (bit_end) begin
          if (bcnt_q == 5'd15) begin
            state_d = S_GAP;
            gcnt_d  = '0;
            done_d  = 1'b1;
            err_d   = ta_err_q;
            if (rd_q) begin
              // Capture even on a turnaround error so software sees 16'hFFFF.
              rvld_d  = 1'b1;
              rdata_d = rx_d;
            end
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end

      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Pin outputs decode from registered state only, so reset forces them
  // to the idle levels without waiting for a clock.
  always_comb begin
    o_mdc      = 1'b1;
    o_mdio_oe  = 1'b0;
    o_mdio_out = 1'b1;
    case (state_q)
      S_PRE: begin
        o_mdc      = (cnt_q >= CNT_HALF);
        o_mdio_oe  = 1'b1;
        o_mdio_out = 1'b1;
      end
      S_HDR: begin
        o_mdc      = (cnt_q >= CNT_HALF);
        o_mdio_oe  = 1'b1;
        o_mdio_out = tx_q[31];
      end
      S_TA, S_DATA: begin
        o_mdc      = (cnt_q >= CNT_HALF);
        o_mdio_oe  = !rd_q;
        o_mdio_out = rd_q ? 1'b1 : tx_q[31];
      end
      default: begin
        o_mdc      = 1'b1;
        o_mdio_oe  = 1'b0;
        o_mdio_out = 1'b1;
      end
    endcase
  end

  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvld_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// tb_mdio_master_ctrl: scoreboard bench for mdio_master_ctrl with a PHY model and frame capture.
// Expected frames, completion times and read data come from a command-level model of the MDIO protocol.
// Stimulus issues one command at a time; a separate monitor checks every o_done against the scoreboard.
module tb_mdio_master_ctrl;

  localparam int DIV = 20;
  localparam int PRE = 32;
  localparam int GAP = 1;
`ifdef MDIO_CLAUSE45_EN
  localparam bit C45_BUILD = 1'b1;
`else
  localparam bit C45_BUILD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        clause45;
  logic [1:0]  op;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        busy;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        phy_drv;
  logic        phy_val;
  logic [15:0] phy_data;

  typedef struct {
    int          acc;
    int          nbits;
    bit          legal;
    bit          rd;
    bit          err;
    logic [31:0] post;
    logic [31:0] post_oe;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  cap[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = 0;
  bit          rdy_pend = 1'b0;
  int          rdy_cyc = 0;
  logic [15:0] mdl_rdata = 16'h0000;
  event        phy_start;

  // Open-drain style pad: PHY wins when it drives, otherwise the master, else pull-up.
  assign mdio_in = phy_drv ? phy_val : (mdio_oe ? mdio_out : 1'b1);

  mdio_master_ctrl #(
    .MDC_DIV(DIV),
    .PRE_LEN(PRE),
    .GAP_CYC(GAP)
  ) dut (
    .iclk_100m    (clk),
    .irst_n       (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_clause45   (clause45),
    .i_op         (op),
    .i_phy_addr   (phy_addr),
    .i_reg_addr   (reg_addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_rdata_valid(rdata_valid),
    .o_done       (done),
    .o_err        (err),
    .o_busy       (busy),
    .o_mdc        (mdc),
    .o_mdio_out   (mdio_out),
    .o_mdio_oe    (mdio_oe),
    .i_mdio_in    (mdio_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol-level expectation for one command.
  function automatic exp_t model(input bit c45_i, input logic [1:0] op_i, input logic [4:0] phy_i,
                                 input logic [4:0] reg_i, input logic [15:0] wd_i, input bit present,
                                 input logic [15:0] pdata, input int acc);
    exp_t e;
    bit   c45;
    logic [1:0]  st;
    logic [1:0]  ta;
    logic [15:0] dat;
    c45 = c45_i & C45_BUILD;
    if (c45) begin
      e.legal = 1'b1;
      e.rd    = (op_i == 2'b11) || (op_i == 2'b10);
    end else begin
      e.legal = (op_i == 2'b01) || (op_i == 2'b10);
      e.rd    = (op_i == 2'b10);
    end
    st  = c45 ? 2'b00 : 2'b01;
    ta  = e.rd ? 2'b11 : 2'b10;
    dat = e.rd ? 16'hFFFF : wd_i;
    e.acc     = acc;
    e.nbits   = e.legal ? PRE + 32 : 0;
    e.post    = {st, op_i, phy_i, reg_i, ta, dat};
    e.post_oe = e.rd ? {14'h3FFF, 18'h00000} : 32'hFFFF_FFFF;
    e.err     = !e.legal || (e.rd && !present);
    e.rdata   = present ? pdata : 16'hFFFF;
    return e;
  endfunction

  task automatic scramble();
    clause45 = 1'($urandom_range(0, 1));
    op       = 2'($urandom_range(0, 3));
    phy_addr = 5'($urandom_range(0, 31));
    reg_addr = 5'($urandom_range(0, 31));
    wdata    = 16'($urandom_range(0, 65535));
  endtask

  task automatic issue(input bit c45_i, input logic [1:0] op_i, input logic [4:0] phy_i,
                       input logic [4:0] reg_i, input logic [15:0] wd_i, input bit present,
                       input logic [15:0] pdata);
    int   budget;
    exp_t e;
    budget = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    scramble();
    // Fields wander while the block is busy; only the accepted ones matter.
    while (!cmd_ready && budget < 5000) begin
      @(negedge clk);
      scramble();
      budget++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: ready=%0b after %0d cycles, required 1", cmd_ready, budget);
      cmd_valid = 1'b0;
      return;
    end
    clause45 = c45_i;
    op       = op_i;
    phy_addr = phy_i;
    reg_addr = reg_i;
    wdata    = wd_i;
    e = model(c45_i, op_i, phy_i, reg_i, wd_i, present, pdata, cyc);
    sb.push_back(e);
    last_acc = cyc;
    if (e.legal && e.rd && present) begin
      phy_data = pdata;
      ->phy_start;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_mdc"}, 32'(mdc), 32'd1);
    chk({tag, "_oe"}, 32'(mdio_oe), 32'd0);
    chk({tag, "_out"}, 32'(mdio_out), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rvalid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  // PHY: counts MDC falling edges from frame start, answers TA with 0 and shifts data MSB first.
  initial begin
    phy_drv = 1'b0;
    phy_val = 1'b1;
    forever begin
      @(phy_start);
      for (int k = 0; k < PRE + 32; k++) begin
        @(negedge mdc);
        if (k == PRE + 15) begin
          phy_drv = 1'b1;
          phy_val = 1'b0;
        end else if (k >= PRE + 16) begin
          phy_drv = 1'b1;
          phy_val = phy_data[15 - (k - PRE - 16)];
        end else begin
          phy_drv = 1'b0;
        end
      end
      @(posedge done);
      phy_drv = 1'b0;
      phy_val = 1'b1;
    end
  end

  // Capture what the master presents at every MDC rising edge.
  initial begin
    forever begin
      @(posedge mdc);
      #1;
      cap.push_back({mdio_oe, mdio_out});
    end
  end

  // Monitor: pops the scoreboard on every o_done.
  initial begin
    exp_t        e;
    int          n_bad;
    logic [1:0]  want;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: o_done=1 with no command outstanding (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.legal ? e.acc + 1 + e.nbits * DIV : e.acc + 1));
            chk("err", 32'(err), 32'(e.err));
            chk("rdata_valid", 32'(rdata_valid), 32'(e.legal && e.rd));
            if (e.legal && e.rd) mdl_rdata = e.rdata;
            chk("rdata", 32'(rdata), 32'(mdl_rdata));
            if (e.legal) begin
              chk("busy_at_done", 32'(busy), 32'd1);
              rdy_pend = 1'b1;
              rdy_cyc  = cyc + GAP * DIV + 1;
            end else begin
              chk("mdc_idle_on_illegal", 32'(mdc), 32'd1);
            end
            chk("frame_len", 32'(cap.size()), 32'(e.nbits));
            if (cap.size() == e.nbits && e.nbits > 0) begin
              n_bad = 0;
              for (int i = 0; i < e.nbits; i++) begin
                if (i < PRE) want = 2'b11;
                else want = {e.post_oe[31 - (i - PRE)], e.post[31 - (i - PRE)]};
                if (cap[i] !== want) n_bad++;
              end
              chk("frame_bits_bad", 32'(n_bad), 32'd0);
            end
            cap.delete();
          end
        end else begin
          if (rdata_valid || err) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse: rdata_valid=%0b err=%0b without o_done, required 0", rdata_valid, err);
          end
        end
        if (rdy_pend) begin
          if (cyc == rdy_cyc - 1) chk("ready_during_gap", 32'(cmd_ready), 32'd0);
          if (cyc == rdy_cyc) begin
            chk("ready_after_gap", 32'(cmd_ready), 32'd1);
            rdy_pend = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #(1_000_000);
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    clause45  = 1'b0;
    op        = 2'b00;
    phy_addr  = 5'd0;
    reg_addr  = 5'd0;
    wdata     = 16'h0000;
    phy_data  = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    @(negedge clk);
    check_reset_vals("reset");

    // Directed cases.
    issue(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0000);
    issue(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b1, 16'h0141);
    issue(1'b0, 2'b10, 5'h04, 5'h01, 16'h0000, 1'b0, 16'h0000);
    issue(1'b0, 2'b11, 5'h02, 5'h03, 16'h5555, 1'b1, 16'h0000);
    issue(1'b0, 2'b00, 5'h07, 5'h09, 16'hA5A5, 1'b1, 16'h0000);
    issue(1'b1, 2'b00, 5'h01, 5'h01, 16'h0001, 1'b1, 16'h0000);
    issue(1'b1, 2'b11, 5'h01, 5'h01, 16'h0000, 1'b1, 16'hBEEF);

    // Reset in the middle of a write: pins idle at once, no completion.
    issue(1'b0, 2'b01, 5'h06, 5'h11, 16'hC3C3, 1'b1, 16'h0000);
    for (int i = 0; i < 5000 && cyc < last_acc + 1 + 40 * DIV + 5; i++) @(negedge clk);
    chk("midframe_oe_before_reset", 32'(mdio_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    sb.delete();
    rdy_pend  = 1'b0;
    mdl_rdata = 16'h0000;
    #2;
    cap.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 2'b01, 5'h06, 5'h11, 16'h3C3C, 1'b1, 16'h0000);
    issue(1'b0, 2'b10, 5'h06, 5'h11, 16'h0000, 1'b1, 16'h1234);

    // Randomised commands.
    for (int n = 0; n < 28; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)),
            ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)));
    end

    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (GAP * DIV + 5) @(negedge clk);
    chk("ready_at_end", 32'(cmd_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
